// File: rtl/norm_shift_reg.sv
// Load/shift register with an auto-normalise sequencer (shift left until MSB=1 or limit).
// Latency: load/manual shift 1 cycle; normalise k+1 cycles from start to done (k = shifts taken).
// Backpressure: none; ld/shen/start are dropped while busy, not queued. Optional rotate via NORM_SHIFT_REG_ROTATE_EN.
module norm_shift_reg #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [WIDTH-1:0] par_in,
    input  logic             shen,
    input  logic             dir,
    input  logic             ser_in,
`ifdef NORM_SHIFT_REG_ROTATE_EN
    input  logic             rot,
`endif
    input  logic             start,
    input  logic [CNT_W-1:0] max_shift,
    output logic [WIDTH-1:0] par_out,
    output logic             msb_out,
    output logic             lsb_out,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             busy,
    output logic             done
);

    if (WIDTH < 2) begin : g_width_chk
        $error("norm_shift_reg: WIDTH must be at least 2");
    end
    if ((64'd1 << CNT_W) <= 64'(WIDTH)) begin : g_cnt_chk
        $error("norm_shift_reg: CNT_W too narrow to count WIDTH shifts");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NORM = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] limit;
    logic [CNT_W-1:0] cnt_inc;
    logic             fill_l;
    logic             fill_r;

    assign cnt_inc = shift_cnt + CNT_W'(1);
    assign msb_out = par_out[WIDTH-1];
    assign lsb_out = par_out[0];

`ifdef NORM_SHIFT_REG_ROTATE_EN
    assign fill_l = rot ? par_out[WIDTH-1] : ser_in;
    assign fill_r = rot ? par_out[0]       : ser_in;
`else
    assign fill_l = ser_in;
    assign fill_r = ser_in;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                // ld outranks start, so a cycle with both only loads
                if (!ld && start) begin
                    if (par_out[WIDTH-1] || (max_shift == '0)) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = ST_NORM;
                    end
                end
            end
            ST_NORM: begin
                // decide on the post-shift value: the bit about to become MSB
                if (par_out[WIDTH-2] || (cnt_inc == limit)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            ST_NORM: busy = 1'b1;
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            par_out   <= '0;
            shift_cnt <= '0;
            limit     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ld) begin
                        par_out   <= par_in;
                        shift_cnt <= '0;
                    end else if (start) begin
                        limit     <= max_shift;
                        shift_cnt <= '0;
                    end else if (shen) begin
                        if (dir) begin
                            par_out <= {fill_r, par_out[WIDTH-1:1]};
                        end else begin
                            par_out <= {par_out[WIDTH-2:0], fill_l};
                        end
                    end
                end
                ST_NORM: begin
                    par_out   <= {par_out[WIDTH-2:0], 1'b0};
                    shift_cnt <= cnt_inc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_norm_shift_reg.sv
// Directed bench for norm_shift_reg: table-driven load/manual-shift vectors plus normalise sequences.
module tb_norm_shift_reg;

    localparam int WIDTH = 16;
    localparam int CNT_W = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             ld;
    logic [WIDTH-1:0] par_in;
    logic             shen;
    logic             dir;
    logic             ser_in;
    logic             rot;
    logic             start;
    logic [CNT_W-1:0] max_shift;
    logic [WIDTH-1:0] par_out;
    logic             msb_out;
    logic             lsb_out;
    logic [CNT_W-1:0] shift_cnt;
    logic             busy;
    logic             done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    norm_shift_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .ld        (ld),
        .par_in    (par_in),
        .shen      (shen),
        .dir       (dir),
        .ser_in    (ser_in),
`ifdef NORM_SHIFT_REG_ROTATE_EN
        .rot       (rot),
`endif
        .start     (start),
        .max_shift (max_shift),
        .par_out   (par_out),
        .msb_out   (msb_out),
        .lsb_out   (lsb_out),
        .shift_cnt (shift_cnt),
        .busy      (busy),
        .done      (done)
    );

    typedef struct {
        logic        ld;
        logic [15:0] par_in;
        logic        shen;
        logic        dir;
        logic        ser_in;
        logic [15:0] exp_par;
        logic [4:0]  exp_cnt;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ld = 0; par_in = '0; shen = 0; dir = 0; ser_in = 0; rot = 0; start = 0; max_shift = '0;
    endtask

    task automatic do_load(input logic [15:0] v);
        ld = 1; par_in = v;
        tick();
        ld = 0;
    endtask

    task automatic run_norm(input string name, input logic [15:0] v, input logic [4:0] lim,
                            input int exp_k, input logic [15:0] exp_par);
        int n;
        do_load(v);
        start = 1; max_shift = lim;
        tick();
        start = 0; max_shift = '0;
        check({name, " busy after start"}, 32'(busy), 32'd1);
        n = 0;
        while (!done && n < 64) begin
            tick();
            n++;
        end
        check({name, " shifts to done"}, n, exp_k);
        check({name, " par_out"}, 32'(par_out), 32'(exp_par));
        check({name, " shift_cnt"}, 32'(shift_cnt), exp_k);
        check({name, " msb_out"}, 32'(msb_out), 32'(exp_par[15]));
        tick();
        check({name, " done is one cycle"}, {30'd0, busy, done}, 32'd0);
        check({name, " cnt holds in idle"}, 32'(shift_cnt), exp_k);
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        tick();
        tick();
        check("reset par_out", 32'(par_out), 32'd0);
        check("reset shift_cnt", 32'(shift_cnt), 32'd0);
        check("reset busy/done", {30'd0, busy, done}, 32'd0);
        rst = 0;

        //          ld  par_in    shen dir ser  exp_par   cnt
        vecs[0] = '{1, 16'hA5A5, 0,   0,  0,   16'hA5A5, 5'd0};
        vecs[1] = '{0, 16'h0000, 1,   1,  1,   16'hD2D2, 5'd0};
        vecs[2] = '{0, 16'h0000, 1,   0,  0,   16'hA5A4, 5'd0};
        vecs[3] = '{1, 16'h1234, 1,   0,  1,   16'h1234, 5'd0};
        vecs[4] = '{0, 16'h0000, 1,   0,  1,   16'h2469, 5'd0};
        vecs[5] = '{0, 16'h0000, 1,   1,  0,   16'h1234, 5'd0};
        vecs[6] = '{0, 16'hFFFF, 0,   1,  1,   16'h1234, 5'd0};
        vecs[7] = '{1, 16'hFFFF, 1,   1,  0,   16'hFFFF, 5'd0};
        vecs[8] = '{0, 16'h0000, 1,   1,  0,   16'h7FFF, 5'd0};
        vecs[9] = '{0, 16'h0000, 1,   0,  0,   16'hFFFE, 5'd0};

        for (int i = 0; i < 10; i++) begin
            ld = vecs[i].ld; par_in = vecs[i].par_in; shen = vecs[i].shen;
            dir = vecs[i].dir; ser_in = vecs[i].ser_in;
            tick();
            idle_inputs();
            check($sformatf("vec%0d par_out", i), 32'(par_out), 32'(vecs[i].exp_par));
            check($sformatf("vec%0d msb/lsb", i), {30'd0, msb_out, lsb_out},
                  {30'd0, vecs[i].exp_par[15], vecs[i].exp_par[0]});
            check($sformatf("vec%0d shift_cnt", i), 32'(shift_cnt), 32'(vecs[i].exp_cnt));
        end

        run_norm("norm 0013", 16'h0013, 5'd16, 11, 16'h9800);
        // manual shift after a normalise must leave the count alone
        shen = 1; dir = 1; ser_in = 0;
        tick();
        idle_inputs();
        check("manual shift keeps cnt", {11'd0, shift_cnt, par_out}, {11'd0, 5'd11, 16'h4C00});

        run_norm("norm zero lim5", 16'h0000, 5'd5, 5, 16'h0000);
        run_norm("norm 8001", 16'h8001, 5'd7, 0, 16'h8001);
        run_norm("norm lim0", 16'h0001, 5'd0, 0, 16'h0001);
        run_norm("norm lim3", 16'h0001, 5'd3, 3, 16'h0008);
        run_norm("norm zero lim20", 16'h0000, 5'd20, 20, 16'h0000);
        run_norm("norm 0001", 16'h0001, 5'd16, 15, 16'h8000);

        // Reset in the 4th NORM cycle abandons the operation.
        do_load(16'h0001);
        start = 1; max_shift = 5'd16;
        tick();
        start = 0;
        tick(); tick(); tick();
        check("pre-reset busy", 32'(busy), 32'd1);
        rst = 1;
        tick();
        rst = 0;
        check("mid-norm reset par_out", 32'(par_out), 32'd0);
        check("mid-norm reset shift_cnt", 32'(shift_cnt), 32'd0);
        check("mid-norm reset busy/done", {30'd0, busy, done}, 32'd0);
        tick();
        check("after reset stays idle", 32'(busy), 32'd0);

        // ld/start/shen pulsed during NORM are ignored.
        do_load(16'h0013);
        start = 1; max_shift = 5'd16;
        tick();
        ld = 1; par_in = 16'hFFFF; shen = 1; dir = 1; ser_in = 1; max_shift = 5'd2;
        tick(); tick(); tick();
        idle_inputs();
        begin
            int n = 3;
            while (!done && n < 64) begin
                tick();
                n++;
            end
            check("ignored ops shifts", n, 11);
        end
        check("ignored ops par_out", 32'(par_out), 32'h9800);
        check("ignored ops shift_cnt", 32'(shift_cnt), 32'd11);
        tick();

`ifdef NORM_SHIFT_REG_ROTATE_EN
        do_load(16'h8001);
        rot = 1; shen = 1; dir = 0; ser_in = 0;
        tick();
        check("rotate left", 32'(par_out), 32'h0003);
        dir = 1;
        tick();
        check("rotate right", 32'(par_out), 32'h8001);
        idle_inputs();
        rot = 1;
        run_norm("norm with rot", 16'h0013, 5'd16, 11, 16'h9800);
        idle_inputs();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
